pipe_mmio: RTL and testbench

Parametrised memory-mapped I/O unit for the MEM stage of the pipelined computer, generalising the fixed two-input / three-output port scheme to N_IN input and N_OUT output ports of width W. It decodes the ALU address and store data that the MEM stage already carries, and holds the output port registers. It synchronises the input ports and returns read data for the MEM-stage load mux. It also adds per-input change detection with sticky flags, a mask register and an interrupt request.

---
 rtl/pipe_mmio_pkg.sv | 25 ++
 rtl/pipe_mmio_sync.sv | 51 +++++
 rtl/pipe_mmio.sv | 131 +++++++++++++
 tb/tb_pipe_mmio.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_mmio_pkg.sv
// pipe_mmio_pkg: shared constants and types for the pipe_mmio unit.
//   IDX_IN_BASE / IDX_MASK / IDX_FLAGS : word indices (addr[6:2]) of the register map
//   warm_t / WARM_TC                   : warm-up sequencer states; WARM_TC means armed
//   reg_hit()                          : register-index match helper
package pipe_mmio_pkg;

  localparam logic [4:0] IDX_IN_BASE = 5'd16;
  localparam logic [4:0] IDX_MASK    = 5'd30;
  localparam logic [4:0] IDX_FLAGS   = 5'd31;

  // Warm-up counts 0..3 after reset; change flags are armed only in the last state.
  typedef enum logic [1:0] {
    WARM_0     = 2'd0,
    WARM_1     = 2'd1,
    WARM_2     = 2'd2,
    WARM_ARMED = 2'd3
  } warm_t;

  localparam warm_t WARM_TC = WARM_ARMED;

  function automatic logic reg_hit(input logic [4:0] idx, input logic [4:0] target);
    return (idx == target);
  endfunction

endpackage

// File: rtl/pipe_mmio_sync.sv
// pipe_mmio_sync: synchroniser for one W-bit input port.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   async_val    : asynchronous port input
//   sync_val     : synchronised value (second stage)
//   chg          : second and third stages differ (only with PIPE_MMIO_IRQ_EN)
// Macro PIPE_MMIO_IRQ_EN adds the third stage used for change detection.
module pipe_mmio_sync #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] async_val,
  output logic [W-1:0] sync_val
`ifdef PIPE_MMIO_IRQ_EN
  ,
  output logic         chg
`endif
);

  logic [W-1:0] s1_r;
  logic [W-1:0] s2_r;

  // Two-flop synchroniser chain.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_r <= '0;
      s2_r <= '0;
    end else begin
      s1_r <= async_val;
      s2_r <= s1_r;
    end
  end

  assign sync_val = s2_r;

`ifdef PIPE_MMIO_IRQ_EN
  logic [W-1:0] s3_r;

  // Delayed copy of the synchronised value for edge detection.
  always_ff @(posedge clock) begin
    if (reset) begin
      s3_r <= '0;
    end else begin
      s3_r <= s2_r;
    end
  end

  assign chg = (s2_r != s3_r);
`endif

endmodule

// File: rtl/pipe_mmio.sv
// pipe_mmio: memory-mapped I/O unit for the MEM stage.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   addr, wdata  : MEM-stage ALU address and store data
//   we           : store enable
//   io_sel       : addr[IO_BIT]; data memory ignores these accesses
//   rdata        : load data for the I/O region (zero-extended)
//   in_ports     : N_IN asynchronous W-bit inputs, port j at [j*W +: W]
//   out_ports    : N_OUT W-bit output registers, same packing
//   irq          : |(FLAGS & MASK)
// Macro PIPE_MMIO_IRQ_EN enables change flags, mask, warm-up and irq;
// without it idx 30/31 read 0 and irq is tied low.
module pipe_mmio
  import pipe_mmio_pkg::*;
#(
  parameter int N_IN   = 2,
  parameter int N_OUT  = 3,
  parameter int W      = 8,
  parameter int IO_BIT = 7
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [31:0]        addr,
  input  logic [31:0]        wdata,
  input  logic               we,
  output logic               io_sel,
  output logic [31:0]        rdata,
  input  logic [N_IN*W-1:0]  in_ports,
  output logic [N_OUT*W-1:0] out_ports,
  output logic               irq
);

  logic [4:0]                idx_s;
  logic                      wr_s;
  logic [N_OUT-1:0][W-1:0]   out_r;
  logic [N_IN-1:0][W-1:0]    sync_s;
  logic [31:0]               rdata_s;
  logic                      unused_s;

  assign idx_s  = addr[6:2];
  assign io_sel = addr[IO_BIT];
  assign wr_s   = we & io_sel;

  // Address bits outside the decode and store-data bits above the port width.
  assign unused_s = ^{addr, wdata};

`ifdef PIPE_MMIO_IRQ_EN
  logic [N_IN-1:0] chg_s;
`endif

  for (genvar j = 0; j < N_IN; j++) begin : g_sync
    pipe_mmio_sync #(.W(W)) u_sync (
      .clock     (clock),
      .reset     (reset),
      .async_val (in_ports[j*W +: W]),
      .sync_val  (sync_s[j])
`ifdef PIPE_MMIO_IRQ_EN
      ,
      .chg       (chg_s[j])
`endif
    );
  end

  // Output port registers; each index only loads on its own store.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_r <= '0;
    end else begin
      for (int j = 0; j < N_OUT; j++) begin
        if (wr_s && reg_hit(idx_s, 5'(j))) begin
          out_r[j] <= wdata[W-1:0];
        end
      end
    end
  end

  assign out_ports = out_r;

`ifdef PIPE_MMIO_IRQ_EN
  logic [N_IN-1:0] mask_r;
  logic [N_IN-1:0] flags_r;
  warm_t           warm_r;
  logic            armed_s;
  logic [N_IN-1:0] clr_s;

  assign armed_s = (warm_r == WARM_TC);
  assign clr_s   = (wr_s && reg_hit(idx_s, IDX_FLAGS)) ? wdata[N_IN-1:0] : '0;

  // Warm-up sequencer, mask register and sticky change flags (set wins over W1C).
  always_ff @(posedge clock) begin
    if (reset) begin
      warm_r  <= WARM_0;
      mask_r  <= '0;
      flags_r <= '0;
    end else begin
      case (warm_r)
        WARM_0:     warm_r <= WARM_1;
        WARM_1:     warm_r <= WARM_2;
        WARM_2:     warm_r <= WARM_ARMED;
        WARM_ARMED: warm_r <= WARM_ARMED;
        default:    warm_r <= WARM_0;
      endcase
      if (wr_s && reg_hit(idx_s, IDX_MASK)) begin
        mask_r <= wdata[N_IN-1:0];
      end
      flags_r <= (flags_r & ~clr_s) | (chg_s & {N_IN{armed_s}});
    end
  end

  assign irq = |(flags_r & mask_r);
`else
  assign irq = 1'b0;
`endif

  // Read mux: at most one term matches idx; unmapped indices read zero.
  always_comb begin
    rdata_s = 32'd0;
    for (int j = 0; j < N_OUT; j++) begin
      rdata_s = rdata_s | (reg_hit(idx_s, 5'(j)) ? 32'(out_r[j]) : 32'd0);
    end
    for (int j = 0; j < N_IN; j++) begin
      rdata_s = rdata_s | (reg_hit(idx_s, IDX_IN_BASE + 5'(j)) ? 32'(sync_s[j]) : 32'd0);
    end
`ifdef PIPE_MMIO_IRQ_EN
    rdata_s = rdata_s | (reg_hit(idx_s, IDX_MASK)  ? 32'(mask_r)  : 32'd0);
    rdata_s = rdata_s | (reg_hit(idx_s, IDX_FLAGS) ? 32'(flags_r) : 32'd0);
`endif
  end

  assign rdata = rdata_s;

endmodule

// File: tb/tb_pipe_mmio.sv
// tb_pipe_mmio: directed self-checking bench for pipe_mmio (defaults N_IN=2,
// N_OUT=3, W=8, IO_BIT=7). Flag/mask/irq checks follow PIPE_MMIO_IRQ_EN.
module tb_pipe_mmio;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic        io_sel;
  logic [31:0] rdata;
  logic [15:0] in_ports;
  logic [23:0] out_ports;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_mmio #(.N_IN(2), .N_OUT(3), .W(8), .IO_BIT(7)) dut (
    .clock     (clock),
    .reset     (reset),
    .addr      (addr),
    .wdata     (wdata),
    .we        (we),
    .io_sel    (io_sel),
    .rdata     (rdata),
    .in_ports  (in_ports),
    .out_ports (out_ports),
    .irq       (irq)
  );

  always #50 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic rd(input logic [31:0] a);
    addr = a;
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    tick();
    we    = 1'b0;
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    addr     = 32'd0;
    wdata    = 32'd0;
    we       = 1'b0;
    in_ports = 16'h0000;
    tick();
    tick();

    // Reset state: every index reads zero, no irq, outputs cleared.
    for (int i = 0; i < 32; i++) begin
      rd(32'h80 + 32'(i * 4));
      check_eq("rst_rdata", rdata, 32'd0);
    end
    check_eq("rst_irq", {31'd0, irq}, 32'd0);
    check_eq("rst_out", {8'd0, out_ports}, 32'd0);
    reset = 1'b0;

    // Store 0xA5 to OUT[1].
    addr  = 32'h84;
    wdata = 32'h0000_00A5;
    we    = 1'b1;
    #1;
    check_eq("io_sel_84", {31'd0, io_sel}, 32'd1);
    tick();
    we = 1'b0;
    #1;
    check_eq("out_after_st1", {8'd0, out_ports}, 32'h0000_A500);
    rd(32'h84);
    check_eq("ld_84", rdata, 32'h0000_00A5);
    rd(32'h87);
    check_eq("ld_87_lowbits", rdata, 32'h0000_00A5);

    wr(32'h80, 32'h0000_0011);
    wr(32'h88, 32'h0000_01FF);
    check_eq("out_all", {8'd0, out_ports}, 32'h00FF_A511);
    rd(32'h88);
    check_eq("ld_88_trunc", rdata, 32'h0000_00FF);
    rd(32'h8C);
    check_eq("ld_8c_unmapped", rdata, 32'd0);

    // Unmapped and read-only indices.
    rd(32'hA8);
    check_eq("ld_a8", rdata, 32'd0);
    wr(32'hA8, 32'h0000_0055);
    check_eq("st_a8_ignored", {8'd0, out_ports}, 32'h00FF_A511);
    wr(32'hC0, 32'h0000_0077);
    rd(32'hC0);
    check_eq("st_c0_ignored", rdata, 32'd0);
    check_eq("st_c0_out", {8'd0, out_ports}, 32'h00FF_A511);

    // Outside the I/O region.
    rd(32'h40);
    check_eq("io_sel_40", {31'd0, io_sel}, 32'd0);
    wr(32'h44, 32'h0000_0099);
    check_eq("st_44_ignored", {8'd0, out_ports}, 32'h00FF_A511);

    // Input latency: change between edges, visible after the second edge.
    in_ports[7:0] = 8'h3C;
    rd(32'hC0);
    check_eq("in0_e_minus", rdata, 32'd0);
    tick();
    rd(32'hC0);
    check_eq("in0_e0", rdata, 32'd0);
    tick();
    rd(32'hC0);
    check_eq("in0_e1", rdata, 32'h0000_003C);

`ifdef PIPE_MMIO_IRQ_EN
    rd(32'hFC);
    check_eq("flags_e1", rdata, 32'd0);
    tick();
    rd(32'hFC);
    check_eq("flags_e2", rdata, 32'd1);
    check_eq("irq_unmasked", {31'd0, irq}, 32'd0);
    wr(32'hF8, 32'h0000_0001);
    check_eq("irq_masked", {31'd0, irq}, 32'd1);
    rd(32'hF8);
    check_eq("mask_rd", rdata, 32'd1);

    in_ports[15:8] = 8'h01;
    tick();
    tick();
    tick();
    rd(32'hFC);
    check_eq("flags_both", rdata, 32'd3);
    wr(32'hFC, 32'h0000_0001);
    rd(32'hFC);
    check_eq("flags_w1c", rdata, 32'd2);
    check_eq("irq_after_clr", {31'd0, irq}, 32'd0);

    // Clear coincides with a new change on port 0: set wins.
    in_ports[7:0] = 8'h3D;
    tick();
    tick();
    wr(32'hFC, 32'h0000_0001);
    rd(32'hFC);
    check_eq("flags_set_wins", rdata, 32'd3);
    check_eq("irq_set_wins", {31'd0, irq}, 32'd1);

    // Toggling every cycle: clears stop working once chg reaches the flag.
    for (int i = 0; i < 6; i++) begin
      in_ports[7:0] = ~in_ports[7:0];
      wr(32'hFC, 32'h0000_0001);
      rd(32'hFC);
      check_eq("flags_toggle", rdata, (i >= 2) ? 32'd3 : 32'd2);
    end

    // Reset mid-store with inputs already nonzero, then warm-up.
    in_ports = 16'h5A5A;
    reset    = 1'b1;
    addr     = 32'h80;
    wdata    = 32'h0000_0033;
    we       = 1'b1;
    tick();
    we = 1'b0;
    check_eq("rst2_out", {8'd0, out_ports}, 32'd0);
    check_eq("rst2_irq", {31'd0, irq}, 32'd0);
    rd(32'hFC);
    check_eq("rst2_flags", rdata, 32'd0);
    rd(32'hF8);
    check_eq("rst2_mask", rdata, 32'd0);
    rd(32'hC0);
    check_eq("rst2_in0", rdata, 32'd0);
    reset = 1'b0;
    tick();
    tick();
    rd(32'hC0);
    check_eq("warm_in0", rdata, 32'h0000_005A);
    rd(32'hFC);
    check_eq("warm_flags_e2", rdata, 32'd0);
    tick();
    rd(32'hFC);
    check_eq("warm_flags_e3", rdata, 32'd0);
    tick();
    tick();
    rd(32'hFC);
    check_eq("warm_flags_e5", rdata, 32'd0);
    in_ports[15:8] = 8'h00;
    tick();
    tick();
    tick();
    rd(32'hFC);
    check_eq("armed_flag1", rdata, 32'd2);
    check_eq("armed_irq_nomask", {31'd0, irq}, 32'd0);
    rd(32'hC4);
    check_eq("armed_in1", rdata, 32'd0);
`else
    for (int i = 0; i < 4; i++) begin
      in_ports[7:0] = ~in_ports[7:0];
      tick();
      check_eq("noirq_irq", {31'd0, irq}, 32'd0);
    end
    wr(32'hF8, 32'h0000_00FF);
    rd(32'hF8);
    check_eq("noirq_f8", rdata, 32'd0);
    wr(32'hFC, 32'h0000_00FF);
    rd(32'hFC);
    check_eq("noirq_fc", rdata, 32'd0);
    tick();
    tick();
    rd(32'hC0);
    check_eq("noirq_in0", rdata, 32'h0000_003C);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
